// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//
// Contents:
//   PAT_W_DEF / CNT_W_DEF : default pattern length and match-counter width
//   RST_PAT_ALL           : reset pattern source (all ones); the detector takes
//                           its low PAT_W bits
//   det_state_e           : FILLING / ARMED detector state names
//
// Optional feature macro used by the detector: SEQ_DET_COUNT_EN.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Widest legal pattern is 32 bits, so 32 ones covers every PAT_W.
  localparam logic [31:0] RST_PAT_ALL = '1;

  // FILLING: fewer than PAT_W valid bits since the last restart.
  // ARMED  : a full PAT_W-bit window is available for comparison.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } det_state_e;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   clk    in  1 : clock, rising edge
//   reset  in  1 : synchronous active-high reset to 0
//   inc    in  1 : increment request (ignored once all ones)
//   clr    in  1 : synchronous clear; wins over inc
//   count  out W : current count
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a runtime-loadable pattern.
//
// Watches a qualified serial stream for a PAT_W-bit pattern (MSB of the
// pattern matches the oldest bit). Overlapping or non-overlapping detection
// is chosen per match by overlap_en. z is a registered one-cycle pulse.
//
// Handshake: bit_in is consumed exactly on cycles where bit_valid is 1; there
// is no backpressure, every valid bit is accepted (except in a pat_load cycle,
// where it is discarded).
//
// Ports:
//   clk          in  1     : clock, rising edge
//   reset        in  1     : synchronous active-high reset
//   bit_in       in  1     : serial data
//   bit_valid    in  1     : qualifies bit_in
//   pat_load     in  1     : capture pat_in, restart the window
//   pat_in       in  PAT_W : new pattern
//   overlap_en   in  1     : 1 = overlapping, 0 = non-overlapping detection
//   cnt_clr      in  1     : clear match_count (wins over a coincident match)
//   z            out 1     : match pulse, one cycle after the final bit's edge
//   match_count  out CNT_W : saturating match count
//   state        out 1     : debug view of the detector state (FILLING/ARMED)
//
// Optional feature: define SEQ_DET_COUNT_EN to build the match counter.
// Without it match_count is tied to 0 and cnt_clr is ignored.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output det_state_e       state
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  shreg, shreg_next;
  logic [FILL_W-1:0] fill, fill_next;
  logic [PAT_W-1:0]  pat_r, pat_next;
  logic              z_next;
  logic              match;

  // Window as it would look after accepting the current bit.
  logic [PAT_W-1:0]  shreg_win;
  logic [FILL_W-1:0] fill_win;

  // The fill counter is the state register; ARMED once the window is full.
  assign state = (fill == FULL) ? ARMED : FILLING;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      fill  <= '0;
      pat_r <= RST_PAT_ALL[PAT_W-1:0];
      z     <= 1'b0;
    end else begin
      shreg <= shreg_next;
      fill  <= fill_next;
      pat_r <= pat_next;
      z     <= z_next;
    end
  end

  always_comb begin
    shreg_next = shreg;
    fill_next  = fill;
    pat_next   = pat_r;
    z_next     = 1'b0;
    match      = 1'b0;
    shreg_win  = {shreg[PAT_W-2:0], bit_in};
    fill_win   = (fill == FULL) ? fill : fill + FILL_W'(1);

    if (pat_load) begin
      // A bit valid in this cycle is dropped; the new pattern starts clean.
      pat_next   = pat_in;
      shreg_next = '0;
      fill_next  = '0;
    end else if (bit_valid) begin
      match      = (fill_win == FULL) && (shreg_win == pat_r);
      shreg_next = shreg_win;
      // Non-overlap restarts the fill so PAT_W fresh bits are needed.
      fill_next  = (match && !overlap_en) ? '0 : fill_win;
      z_next     = match;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  // Counter sees the same reset, so a match on a reset edge is not counted.
  seq_det_sat_cnt #(
    .W(CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule
